// File: rtl/wd_pkg.sv
// Shared watchdog definitions: register map, CTRL bit positions and the default kick key.
package wd_pkg;

    localparam logic [7:0] WD_CTRL    = 8'h00;
    localparam logic [7:0] WD_LOAD_LO = 8'h04;
    localparam logic [7:0] WD_LOAD_HI = 8'h08;
    localparam logic [7:0] WD_VAL_LO  = 8'h0C;
    localparam logic [7:0] WD_VAL_HI  = 8'h10;
    localparam logic [7:0] WD_KICK    = 8'h14;
    localparam logic [7:0] WD_STATUS  = 8'h18;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_INTEN = 1;
    localparam int CTRL_RSTEN = 2;

    localparam logic [7:0] WD_KICK_KEY = 8'h5A;

    // Field order matches the CTRL bit indices above (en is bit 0).
    typedef struct packed {
        logic rsten;
        logic inten;
        logic en;
    } wd_ctrl_t;

endpackage

// File: rtl/wd_cnt.sv
// Watchdog down-counter: reloads on request or after reaching zero, flags expiry while enabled.
module wd_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    input  logic             reload,
    output logic [CNT_W-1:0] value,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire = en && (cnt_q == '0);
    assign value  = cnt_q;

    // An explicit reload wins; an expired counter restarts from LOAD instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (reload) begin
            cnt_d = load_val;
        end else if (expire) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '1;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wd_timer.sv
// APB-programmable watchdog: register file, keyed kick, two-stage expiry (interrupt, then sticky timeout).
module wd_timer
    import wd_pkg::*;
#(
    parameter int         CNT_W    = 16,
    parameter logic [7:0] KICK_KEY = WD_KICK_KEY
) (
    input  logic       pclk,
    input  logic       preset_n,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       intr,
    output logic       timeout
);

    wd_ctrl_t         ctrl_q;
    wd_ctrl_t         ctrl_d;
    logic [CNT_W-1:0] load_q;
    logic [CNT_W-1:0] load_d;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_expire;
    logic             rawint_q;
    logic             rawint_d;
    logic             tmo_q;
    logic             tmo_d;
    logic             intr_q;
    logic             timeout_q;
    logic [7:0]       prdata_q;
    logic [7:0]       rd_data;
    logic             wr_en;
    logic             rd_setup;
    logic             kick;
    logic             load_wr;
    logic [15:0]      load_ext;
    logic [15:0]      val_ext;

    assign wr_en    = psel & penable & pwrite;
    assign rd_setup = psel & ~penable & ~pwrite;
    assign kick     = wr_en && (paddr == WD_KICK) && (pwdata == KICK_KEY);
    assign load_wr  = wr_en && ((paddr == WD_LOAD_LO) || (paddr == WD_LOAD_HI));

    always_comb begin
        ctrl_d = ctrl_q;
        load_d = load_q;
        if (wr_en) begin
            case (paddr)
                WD_CTRL:    ctrl_d = wd_ctrl_t'(pwdata[2:0]);
                WD_LOAD_LO: load_d[7:0] = pwdata;
                WD_LOAD_HI: load_d[CNT_W-1:8] = pwdata[CNT_W-9:0];
                default:    ;
            endcase
        end
    end

    // load_d carries a same-edge LOAD write so the reload picks up the new value.
    wd_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (pclk),
        .rst_n    (preset_n),
        .en       (ctrl_q.en),
        .load_val (load_d),
        .reload   (kick | load_wr),
        .value    (cnt_value),
        .expire   (cnt_expire)
    );

    // Kick and LOAD-write reloads both pre-empt the expiry on the same edge.
    always_comb begin
        rawint_d = rawint_q;
        tmo_d    = tmo_q;
        if (kick) begin
            rawint_d = 1'b0;
        end else if (!load_wr && cnt_expire) begin
            if (!rawint_q) begin
                rawint_d = 1'b1;
            end else if (ctrl_q.rsten) begin
                tmo_d = 1'b1;
            end
        end
    end

    assign load_ext = 16'(load_q);
    assign val_ext  = 16'(cnt_value);

    always_comb begin
        rd_data = 8'h00;
        case (paddr)
            WD_CTRL:    rd_data = {5'b0, ctrl_q};
            WD_LOAD_LO: rd_data = load_ext[7:0];
            WD_LOAD_HI: rd_data = load_ext[15:8];
            WD_VAL_LO:  rd_data = val_ext[7:0];
            WD_VAL_HI:  rd_data = val_ext[15:8];
            WD_STATUS:  rd_data = {6'b0, tmo_q, rawint_q};
            default:    rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            ctrl_q    <= '0;
            load_q    <= '1;
            rawint_q  <= 1'b0;
            tmo_q     <= 1'b0;
            intr_q    <= 1'b0;
            timeout_q <= 1'b0;
            prdata_q  <= 8'h00;
        end else begin
            ctrl_q    <= ctrl_d;
            load_q    <= load_d;
            rawint_q  <= rawint_d;
            tmo_q     <= tmo_d;
            intr_q    <= rawint_q & ctrl_q.inten;
            timeout_q <= tmo_q;
            if (rd_setup) begin
                prdata_q <= rd_data;
            end
        end
    end

    assign prdata  = prdata_q;
    assign intr    = intr_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_wd_timer.sv
// Watchdog bench: directed scenarios plus random APB traffic against an elapsed-cycle reference model.
module tb_wd_timer;
    import wd_pkg::*;

    logic       pclk     = 1'b0;
    logic       preset_n = 1'b0;
    logic       psel     = 1'b0;
    logic       penable  = 1'b0;
    logic       pwrite   = 1'b0;
    logic [7:0] paddr    = 8'h00;
    logic [7:0] pwdata   = 8'h00;
    logic [7:0] prdata;
    logic       intr;
    logic       timeout;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic seen_any = 1'b0;

    // Reference model: counter value is LOAD minus enabled cycles elapsed since the last reload.
    logic [2:0] m_ctrl    = 3'b000;
    int         m_load    = 65535;
    int         m_elapsed = 0;
    logic       m_raw     = 1'b0;
    logic       m_to      = 1'b0;
    logic       m_intr    = 1'b0;
    logic       m_tout    = 1'b0;
    logic [7:0] m_rd      = 8'h00;

    wd_timer dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .intr     (intr),
        .timeout  (timeout)
    );

    always #5 pclk = ~pclk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] a);
        logic [15:0] v = 16'(m_load - m_elapsed);
        logic [15:0] l = 16'(m_load);
        case (a)
            WD_CTRL:    return {5'b0, m_ctrl};
            WD_LOAD_LO: return l[7:0];
            WD_LOAD_HI: return l[15:8];
            WD_VAL_LO:  return v[7:0];
            WD_VAL_HI:  return v[15:8];
            WD_STATUS:  return {6'b0, m_to, m_raw};
            default:    return 8'h00;
        endcase
    endfunction

    task automatic model_step();
        logic [2:0]  c = m_ctrl;
        logic        en;
        logic        wr;
        logic        kick;
        logic        ldw;
        logic        expd;
        logic [15:0] ld;
        en   = c[CTRL_EN];
        wr   = psel && penable && pwrite;
        kick = wr && (paddr == WD_KICK) && (pwdata == WD_KICK_KEY);
        ldw  = wr && ((paddr == WD_LOAD_LO) || (paddr == WD_LOAD_HI));
        expd = en && (m_elapsed == m_load);
        if (psel && !penable && !pwrite) m_rd = model_read(paddr);
        m_intr = m_raw && c[CTRL_INTEN];
        m_tout = m_to;
        if (wr && paddr == WD_CTRL) m_ctrl = pwdata[2:0];
        ld = 16'(m_load);
        if (wr && paddr == WD_LOAD_LO) ld[7:0] = pwdata;
        if (wr && paddr == WD_LOAD_HI) ld[15:8] = pwdata;
        m_load = int'(ld);
        if (kick) begin
            m_raw = 1'b0;
            m_elapsed = 0;
        end else if (ldw) begin
            m_elapsed = 0;
        end else if (expd) begin
            if (!m_raw) m_raw = 1'b1;
            else if (c[CTRL_RSTEN]) m_to = 1'b1;
            m_elapsed = 0;
        end else if (en) begin
            m_elapsed++;
        end
    endtask

    initial begin
        forever begin
            @(posedge pclk or negedge preset_n);
            if (!preset_n) begin
                m_ctrl = 3'b000; m_load = 65535; m_elapsed = 0;
                m_raw = 1'b0; m_to = 1'b0; m_intr = 1'b0; m_tout = 1'b0; m_rd = 8'h00;
            end else begin
                model_step();
            end
        end
    end

    initial begin
        forever begin
            @(negedge pclk);
            check_val("intr_vs_model", 32'(intr), 32'(m_intr));
            check_val("timeout_vs_model", 32'(timeout), 32'(m_tout));
        end
    end

    task automatic apb_write(input logic [7:0] addr, input logic [7:0] data);
        $display("APB WR addr=0x%02h data=0x%02h", addr, data);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = addr; pwdata = data;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] addr, output logic [7:0] data);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = addr;
        @(negedge pclk);
        penable = 1'b1;
        data = prdata;
        check_val("read_vs_model", 32'(prdata), 32'(m_rd));
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        $display("APB RD addr=0x%02h data=0x%02h", addr, data);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge pclk);
            seen_any = seen_any | intr | timeout;
        end
    endtask

    task automatic wait_sig(input int which, input int bound, output int n);
        n = 0;
        while ((((which == 0) ? intr : timeout) !== 1'b1) && (n < bound)) begin
            @(negedge pclk);
            n++;
        end
    endtask

    task automatic do_reset();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        preset_n = 1'b0;
        repeat (2) @(negedge pclk);
        preset_n = 1'b1;
        $display("RESET released");
    endtask

    task automatic setup_wd(input logic [7:0] lo, input logic [7:0] ctrl);
        apb_write(WD_LOAD_LO, lo);
        apb_write(WD_LOAD_HI, 8'h00);
        apb_write(WD_CTRL, ctrl);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         n;
        logic [7:0] d;
        logic [7:0] a;
        int         op;

        @(negedge pclk);
        do_reset();

        check_val("rst_intr", 32'(intr), 32'h0);
        check_val("rst_timeout", 32'(timeout), 32'h0);
        apb_read(WD_CTRL, d);    check_val("rst_ctrl", 32'(d), 32'h00);
        apb_read(WD_LOAD_LO, d); check_val("rst_load_lo", 32'(d), 32'hFF);
        apb_read(WD_LOAD_HI, d); check_val("rst_load_hi", 32'(d), 32'hFF);
        apb_read(WD_STATUS, d);  check_val("rst_status", 32'(d), 32'h00);
        apb_read(8'h20, d);      check_val("rst_unmapped", 32'(d), 32'h00);
        apb_read(WD_VAL_HI, d);  check_val("rst_val_hi", 32'(d), 32'hFF);

        // LOAD=16, interrupt only: intr rises LOAD+2 edges after the enabling write edge.
        setup_wd(8'h10, 8'h03);
        wait_sig(0, 40, n);
        check_val("intr_latency", 32'(n), 32'd18);
        apb_read(WD_STATUS, d);  check_val("status_rawint", 32'(d), 32'h01);

        // Same with RSTEN: timeout LOAD+1 edges after intr, sticky through a kick.
        do_reset();
        setup_wd(8'h10, 8'h07);
        wait_sig(0, 40, n);
        check_val("intr_latency_rsten", 32'(n), 32'd18);
        wait_sig(1, 40, n);
        check_val("timeout_after_intr", 32'(n), 32'd17);
        apb_read(WD_STATUS, d);  check_val("status_both", 32'(d), 32'h03);
        apb_write(WD_KICK, 8'h5A);
        idle(1);
        check_val("kick_drops_intr", 32'(intr), 32'h0);
        check_val("timeout_survives_kick", 32'(timeout), 32'h1);
        idle(30);
        check_val("timeout_sticky", 32'(timeout), 32'h1);
        do_reset();
        check_val("timeout_cleared_by_reset", 32'(timeout), 32'h0);

        // Regular kicks every 6 cycles with LOAD=8 keep the watchdog quiet.
        setup_wd(8'h08, 8'h07);
        seen_any = 1'b0;
        for (int i = 0; i < 17; i++) begin
            apb_write(WD_KICK, 8'h5A);
            idle(4);
        end
        check_val("kicked_never_fires", 32'(seen_any), 32'h0);
        // Wrong key: intr still due LOAD+2 after the last valid kick, i.e. 4 cycles after this write.
        apb_write(WD_KICK, 8'h33);
        wait_sig(0, 20, n);
        check_val("bad_key_ignored", 32'(n), 32'd4);

        // Kick lands exactly on the expiry edge.
        do_reset();
        setup_wd(8'h08, 8'h07);
        idle(7);
        apb_write(WD_KICK, 8'h5A);
        apb_read(WD_VAL_LO, d);  check_val("kick_at_zero_val", 32'(d), 32'h08);
        apb_read(WD_STATUS, d);  check_val("kick_at_zero_status", 32'(d), 32'h00);

        // LOAD=0: expiry every cycle.
        do_reset();
        setup_wd(8'h00, 8'h07);
        wait_sig(0, 10, n);
        check_val("load0_intr", 32'(n), 32'd2);
        wait_sig(1, 10, n);
        check_val("load0_timeout", 32'(n), 32'd1);

        // Reset asserted in the access phase of a CTRL write.
        do_reset();
        $display("APB WR addr=0x%02h data=0x%02h (aborted by reset)", WD_CTRL, 8'h07);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = WD_CTRL; pwdata = 8'h07;
        @(negedge pclk);
        penable = 1'b1;
        #2 preset_n = 1'b0;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(negedge pclk);
        preset_n = 1'b1;
        apb_read(WD_CTRL, d);    check_val("abort_ctrl", 32'(d), 32'h00);
        apb_read(WD_VAL_LO, d);  check_val("abort_val_lo", 32'(d), 32'hFF);
        idle(5);
        apb_read(WD_VAL_LO, d);  check_val("abort_val_hold", 32'(d), 32'hFF);
        apb_read(WD_VAL_HI, d);  check_val("abort_val_hi", 32'(d), 32'hFF);

        // Random APB traffic, checked cycle by cycle against the model.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 9);
            a  = 8'($urandom_range(0, 8) * 4);
            case (op)
                0, 1: apb_write(WD_CTRL, 8'($urandom_range(0, 255)));
                2:    apb_write(WD_LOAD_LO, 8'($urandom_range(0, 24)));
                3:    apb_write(WD_LOAD_HI, ($urandom_range(0, 9) == 0) ? 8'h01 : 8'h00);
                4, 5: apb_write(WD_KICK, ($urandom_range(0, 1) == 1) ? 8'h5A : 8'($urandom_range(0, 255)));
                6, 7: apb_read(a, d);
                8:    idle($urandom_range(1, 6));
                default: begin
                    if (a != WD_LOAD_LO && a != WD_LOAD_HI && a != WD_CTRL)
                        apb_write(a, 8'($urandom_range(0, 255)));
                    else
                        apb_read(a, d);
                end
            endcase
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
